// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - sequenced multi-domain reset request generator with debounce and ack handshake
module reset_sequencer #(
    parameter int N_OUT           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 4,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             btn_resetn,
    input  logic             pll_locked,
    input  logic [N_OUT-1:0] ack_resetn,
    output logic [N_OUT-1:0] out_resetn,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] timeout_err
);
    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_B = (STAGE_GAP > ACK_TIMEOUT) ? STAGE_GAP : ACK_TIMEOUT;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam int DW    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_GAP,
        ST_RUN
    } state_t;

    // Synchronizers carry no reset; power-up values keep the button idle and the PLL unlocked.
    logic [1:0]       btn_sync  = 2'b11;
    logic [1:0]       pll_sync  = 2'b00;
    logic [N_OUT-1:0] ack_sync1 = '0;
    logic [N_OUT-1:0] ack_sync2 = '0;

    always_ff @(posedge clk) begin
        btn_sync  <= {btn_sync[0], btn_resetn};
        pll_sync  <= {pll_sync[0], pll_locked};
        ack_sync1 <= ack_resetn;
        ack_sync2 <= ack_sync1;
    end

    logic             btn_s;
    logic             pll_s;
    logic [N_OUT-1:0] ack_s;

    assign btn_s = btn_sync[1];
    assign pll_s = pll_sync[1];
    assign ack_s = ack_sync2;

    logic [DW-1:0] db_cnt;
    logic          press;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= !btn_s && (db_cnt == DB_LAST);
            if (btn_s) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [IW-1:0]    idx, idx_next;
    logic [N_OUT-1:0] out_q, out_next;
    logic [N_OUT-1:0] err_q, err_next;
    logic             abort;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_ASSERT;
            cnt   <= '0;
            idx   <= '0;
            out_q <= '0;
            err_q <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            out_q <= out_next;
            err_q <= err_next;
            busy  <= (state_next != ST_RUN);
            done  <= (state_next == ST_RUN);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        out_next   = out_q;
        err_next   = err_q;
        abort      = !pll_s || press;

        case (state)
            ST_ASSERT: begin
                out_next = '0;
                if (ack_s == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                end else if (cnt == ACK_LAST) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    err_next   = err_q | ack_s;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if ((cnt >= HOLD_LAST) && pll_s && btn_s) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (cnt < HOLD_LAST) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                out_next[idx] = 1'b1;
                state_next    = ST_WAIT_ACK;
                cnt_next      = '0;
            end
            ST_WAIT_ACK: begin
                if (ack_s[idx] || (cnt == ACK_LAST)) begin
                    if (!ack_s[idx]) begin
                        err_next[idx] = 1'b1;
                    end
                    cnt_next   = '0;
                    state_next = (idx == IDX_LAST) ? ST_RUN : ST_GAP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    idx_next   = idx + 1'b1;
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = '0;
            end
        endcase

        // During ASSERT/HOLD a press or PLL loss is already covered by HOLD's release gate.
        if (abort && (state == ST_RELEASE || state == ST_WAIT_ACK ||
                      state == ST_GAP || state == ST_RUN)) begin
            state_next = ST_ASSERT;
            out_next   = '0;
            idx_next   = '0;
            cnt_next   = '0;
        end
    end

    assign out_resetn  = out_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;
    localparam int N_OUT = 2;
    localparam int DEB   = 8;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             btn_resetn;
    logic             pll_locked;
    logic [N_OUT-1:0] ack_resetn;
    logic [N_OUT-1:0] out_resetn;
    logic [N_OUT-1:0] timeout_err;
    logic             busy;
    logic             done;
    logic             ack1_block;

    logic [1:0] d1 = '0, d2 = '0, d3 = '0;
    logic [1:0] a1 = '0, a2 = '0;
    int cyc = 0;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_q[$];
    logic       mon_en   = 1'b0;
    logic [1:0] prev_out = '0;
    logic       prev_a0  = 1'b0;
    int         ack0_cyc = 0;

    reset_sequencer #(
        .N_OUT(N_OUT), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .STAGE_GAP(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .btn_resetn(btn_resetn), .pll_locked(pll_locked),
        .ack_resetn(ack_resetn), .out_resetn(out_resetn), .busy(busy), .done(done),
        .timeout_err(timeout_err)
    );

    // Downstream domain model: ack follows the request 3 cycles later; a2 mirrors the DUT's ack_s.
    always @(posedge clk) begin
        d1  <= out_resetn;
        d2  <= d1;
        d3  <= d2;
        a1  <= ack_resetn;
        a2  <= a1;
        cyc <= cyc + 1;
    end
    assign ack_resetn = {d3[1] & ~ack1_block, d3[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (a2[0] && !prev_a0) ack0_cyc = cyc;
            if (out_resetn !== prev_out) begin
                if (out_resetn[1] && !prev_out[1]) begin
                    check("order_ack0", a2[0], 1'b1);
                    check("order_gap", cyc - ack0_cyc, GAP + 2);
                end
                if (exp_q.size() == 0) check("sb_unexpected", out_resetn, prev_out);
                else check("sb_out", out_resetn, exp_q.pop_front());
                prev_out = out_resetn;
            end
        end
        prev_a0 = a2[0];
    end

    task automatic wait_done(input int limit, input string tag);
        int i = 0;
        while (i < limit && !done) begin
            @(negedge clk);
            i++;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic wait_out(input logic [1:0] val, input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (out_resetn == val) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        resetn     = 1'b0;
        btn_resetn = 1'b1;
        pll_locked = 1'b1;
        ack1_block = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rst_out", out_resetn, 2'b00);
        check("rst_busy", busy, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", timeout_err, 2'b00);

        // Power-on release
        mon_en = 1'b1;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        resetn = 1'b1;
        repeat (HOLD + 1) @(posedge clk);
        @(negedge clk);
        check("po_hold", out_resetn, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check("po_first", out_resetn, 2'b01);
        wait_done(100, "po_done");
        check("po_out", out_resetn, 2'b11);
        check("po_busy", busy, 1'b0);
        check("po_err", timeout_err, 2'b00);
        check("po_sb_empty", exp_q.size(), 0);

        // Short button glitch is ignored
        btn_resetn = 1'b0;
        repeat (5) @(negedge clk);
        btn_resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_out", out_resetn, 2'b11);
        check("glitch_done", done, 1'b1);

        // Real press
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        btn_resetn = 1'b0;
        wait_out(2'b00, 30, n);
        check("btn_latency", n, 11);
        repeat (20 - n) @(negedge clk);
        check("btn_hold_low", out_resetn, 2'b00);
        btn_resetn = 1'b1;
        wait_done(200, "btn_done");
        check("btn_sb_empty", exp_q.size(), 0);

        // PLL loss in RUN
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        pll_locked = 1'b0;
        wait_out(2'b00, 10, n);
        check("pll_latency", n, 3);
        check("pll_busy", busy, 1'b1);
        check("pll_done", done, 1'b0);
        repeat (8) @(negedge clk);
        pll_locked = 1'b1;
        wait_done(200, "pll_done_relock");
        check("pll_sb_empty", exp_q.size(), 0);

        // Stage 1 acknowledge never arrives
        ack1_block = 1'b1;
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
        pll_locked = 1'b0;
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;
        wait_out(2'b11, 200, n);
        check("tmo_stage1", out_resetn, 2'b11);
        check("tmo_err_pre", timeout_err, 2'b00);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (timeout_err != 2'b00) break;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_err", timeout_err, 2'b10);
        check("tmo_done", done, 1'b1);
        ack1_block = 1'b0;

        // resetn asserted while in GAP
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        pll_locked = 1'b0;
        repeat (6) @(negedge clk);
        pll_locked = 1'b1;
        wait_out(2'b01, 200, n);
        check("mg_first", out_resetn, 2'b01);
        n = 0;
        while (!a2[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mg_ack0", a2[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mg_out", out_resetn, 2'b00);
        check("mg_busy", busy, 1'b1);
        check("mg_done", done, 1'b0);
        check("mg_err", timeout_err, 2'b00);
        repeat (2) @(negedge clk);
        check("end_sb_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
